// File: rtl/sev_seg_pkg.sv
// Shared mode encodings, blank pattern and hex-to-segment decode for the
// multiplexed seven-segment message scroller.
package sev_seg_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC   = 2'b00,
        MODE_SCROLL_L = 2'b01,
        MODE_SCROLL_R = 2'b10,
        MODE_WALK     = 2'b11
    } mode_e;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low cathodes {dp, g..a}; the DP cathode is pulled low when lit.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble, input logic dp);
        logic [7:0] pat;
        case (nibble)
            4'h0:    pat = 8'hC0;
            4'h1:    pat = 8'hF9;
            4'h2:    pat = 8'hA4;
            4'h3:    pat = 8'hB0;
            4'h4:    pat = 8'h99;
            4'h5:    pat = 8'h92;
            4'h6:    pat = 8'h82;
            4'h7:    pat = 8'hF8;
            4'h8:    pat = 8'h80;
            4'h9:    pat = 8'h90;
            4'hA:    pat = 8'h88;
            4'hB:    pat = 8'h83;
            4'hC:    pat = 8'hC6;
            4'hD:    pat = 8'hA1;
            4'hE:    pat = 8'h86;
            4'hF:    pat = 8'h8E;
            default: pat = SEG_BLANK;
        endcase
        return {pat[7] & ~dp, pat[6:0]};
    endfunction

endpackage

// File: rtl/sev_seg_tick.sv
// Modulo-DIV cycle divider: TICK is high during the last count of each
// period, so the consuming register updates on the DIV-th edge.
module sev_seg_tick #(
    parameter int DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic TICK
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    // Period counter; freezes while EN is low so a re-enable resumes mid-period.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r <= {CW{1'b0}};
        end else if (EN) begin
            if (cnt_r == LAST) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1'b1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign TICK = EN & (cnt_r == LAST);

endmodule

// File: rtl/sev_seg_scroll.sv
// Multiplexed common-anode seven-segment driver that scans NUM_DIGITS digits
// out of a MSG_LEN-nibble message with static, scroll and walk modes.
module sev_seg_scroll
    import sev_seg_pkg::*;
#(
    parameter  int NUM_DIGITS  = 8,
    parameter  int MSG_LEN     = 16,
    parameter  int REFRESH_DIV = 100000,
    parameter  int STEP_DIV    = 50000000,
    localparam int OW          = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic [1:0]             MODE,
    input  logic [4*MSG_LEN-1:0]   DATA,
    input  logic [MSG_LEN-1:0]     DP,
    output logic [7:0]             SSEG_CA,
    output logic [NUM_DIGITS-1:0]  SSEG_AN,
    output logic [OW-1:0]          OFFSET,
    output logic                   STEP
);

    localparam int                    SW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int                    IW        = OW + 1;
    localparam logic [SW-1:0]         S_LAST    = SW'(NUM_DIGITS - 1);
    localparam logic [OW-1:0]         OFF_LAST  = OW'(MSG_LEN - 1);
    localparam logic [IW-1:0]         MSG_LEN_W = IW'(MSG_LEN);
    localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1'b1);

    mode_e                 state_r, state_nx_s;
    logic                  mode_chg_s, step_clr_s, rtick_s, stick_s, step_s;
    logic [SW-1:0]         s_r, s_nx_s, w_r, w_nx_s;
    logic [OW-1:0]         offset_r, offset_nx_s;
    logic [IW-1:0]         idx_sum_s, idx_s;
    logic [3:0]            nib_s;
    logic                  dp_bit_s, lit_s, step_r;
    logic [7:0]            seg_s, ca_r;
    logic [NUM_DIGITS-1:0] an_dig_s, an_r;

    // A mode change restarts the step period so the first step is a full period away.
    assign mode_chg_s = (mode_e'(MODE) != state_r);
    assign step_clr_s = RST | mode_chg_s;

    sev_seg_tick #(.DIV(REFRESH_DIV)) u_refresh (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .TICK (rtick_s)
    );

    sev_seg_tick #(.DIV(STEP_DIV)) u_step (
        .CLK  (CLK),
        .RST  (step_clr_s),
        .EN   (EN),
        .TICK (stick_s)
    );

    // Mode FSM next state: offset/walk updates, mode change wins over a step.
    always_comb begin
        state_nx_s  = mode_e'(MODE);
        offset_nx_s = offset_r;
        w_nx_s      = w_r;
        step_s      = 1'b0;
        if (mode_chg_s) begin
            offset_nx_s = {OW{1'b0}};
            w_nx_s      = {SW{1'b0}};
        end else if (stick_s) begin
            step_s = 1'b1;
            case (state_r)
                MODE_SCROLL_L: offset_nx_s = (offset_r == OFF_LAST) ? {OW{1'b0}} : offset_r + OW'(1'b1);
                MODE_SCROLL_R: offset_nx_s = (offset_r == {OW{1'b0}}) ? OFF_LAST : offset_r - OW'(1'b1);
                MODE_WALK: begin
                    offset_nx_s = {OW{1'b0}};
                    w_nx_s      = (w_r == S_LAST) ? {SW{1'b0}} : w_r + SW'(1'b1);
                end
                MODE_STATIC:   offset_nx_s = {OW{1'b0}};
                default: begin
                    offset_nx_s = {OW{1'b0}};
                    w_nx_s      = {SW{1'b0}};
                end
            endcase
        end else begin
            offset_nx_s = offset_r;
            w_nx_s      = w_r;
        end
    end

    // Scan index and the segment/anode pattern for the slot about to be loaded.
    always_comb begin
        s_nx_s    = s_r;
        idx_s     = {IW{1'b0}};
        nib_s     = 4'h0;
        dp_bit_s  = 1'b0;
        if (rtick_s) begin
            s_nx_s = (s_r == S_LAST) ? {SW{1'b0}} : s_r + SW'(1'b1);
        end else begin
            s_nx_s = s_r;
        end
        // Both terms are below MSG_LEN, so one conditional subtract is the modulo.
        idx_sum_s = IW'(offset_r) + IW'(s_r);
        if (idx_sum_s >= MSG_LEN_W) begin
            idx_s = idx_sum_s - MSG_LEN_W;
        end else begin
            idx_s = idx_sum_s;
        end
        for (int i = 0; i < MSG_LEN; i++) begin
            if (idx_s == IW'(i)) begin
                nib_s    = DATA[4*i +: 4];
                dp_bit_s = DP[i];
            end else begin
                nib_s    = nib_s;
                dp_bit_s = dp_bit_s;
            end
        end
        seg_s    = hex_to_seg(nib_s, dp_bit_s);
        an_dig_s = ~(AN_ONE << s_r);
        lit_s    = (state_r != MODE_WALK) || (s_r == w_r);
    end

    // Control registers: mode, scroll offset, walk position, scan index, step pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= MODE_STATIC;
            offset_r <= {OW{1'b0}};
            w_r      <= {SW{1'b0}};
            s_r      <= {SW{1'b0}};
            step_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            offset_r <= offset_nx_s;
            w_r      <= w_nx_s;
            s_r      <= s_nx_s;
            step_r   <= step_s;
        end
    end

    // Anodes and cathodes load together so a slot never mixes two digits.
    always_ff @(posedge CLK) begin
        if (RST) begin
            an_r <= AN_OFF;
            ca_r <= SEG_BLANK;
        end else if (!EN) begin
            an_r <= AN_OFF;
            ca_r <= SEG_BLANK;
        end else if (rtick_s) begin
            if (lit_s) begin
                an_r <= an_dig_s;
                ca_r <= seg_s;
            end else begin
                an_r <= AN_OFF;
                ca_r <= SEG_BLANK;
            end
        end else begin
            an_r <= an_r;
            ca_r <= ca_r;
        end
    end

    assign SSEG_AN = an_r;
    assign SSEG_CA = ca_r;
    assign OFFSET  = offset_r;
    assign STEP    = step_r;

endmodule

// File: tb/tb_sev_seg_scroll.sv
// Directed scoreboard bench for sev_seg_scroll with 4 digits, 6 nibbles,
// refresh every 4 cycles and a step every 32 cycles.
module tb_sev_seg_scroll;

    localparam int ND = 4;
    localparam int ML = 6;
    localparam int RD = 4;
    localparam int SD = 32;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [1:0]  mode;
    logic [23:0] data;
    logic [5:0]  dp;
    logic [7:0]  ca;
    logic [3:0]  an;
    logic [2:0]  off;
    logic        stp;

    int cyc;
    int checks;
    int errors;

    typedef struct {
        string      tag;
        int         at;
        bit         disp;
        bit         chk_step;
        logic [3:0] an;
        logic [7:0] ca;
        logic [2:0] off;
        logic       stp;
    } exp_t;

    exp_t exp_q[$];

    sev_seg_scroll #(
        .NUM_DIGITS  (ND),
        .MSG_LEN     (ML),
        .REFRESH_DIV (RD),
        .STEP_DIV    (SD)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .EN      (en),
        .MODE    (mode),
        .DATA    (data),
        .DP      (dp),
        .SSEG_CA (ca),
        .SSEG_AN (an),
        .OFFSET  (off),
        .STEP    (stp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Queue the expectation, run to cycle 'at' (counted from reset release), then score it.
    task automatic expect_at(input string tag, input int at, input bit disp, input bit chk_step,
                             input logic [3:0] e_an, input logic [7:0] e_ca,
                             input logic [2:0] e_off, input logic e_stp);
        exp_t e;
        e.tag = tag; e.at = at; e.disp = disp; e.chk_step = chk_step;
        e.an = e_an; e.ca = e_ca; e.off = e_off; e.stp = e_stp;
        exp_q.push_back(e);
        while (cyc < at) tick();
        e = exp_q.pop_front();
        if (e.disp) begin
            cmp({e.tag, "_an"}, {4'h0, an}, {4'h0, e.an});
            cmp({e.tag, "_ca"}, ca, e.ca);
        end
        cmp({e.tag, "_off"}, {5'h0, off}, {5'h0, e.off});
        if (e.chk_step) cmp({e.tag, "_step"}, {7'h0, stp}, {7'h0, e.stp});
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [23:0] d, input logic [5:0] p);
        mode = m;
        data = d;
        dp   = p;
        en   = 1'b1;
        rst  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        cyc = 0; checks = 0; errors = 0;
        rst = 1'b1; en = 1'b0; mode = 2'b00; data = 24'h0; dp = 6'h0;

        // Reset and static scan
        do_reset(2'b00, 24'h543210, 6'h00);
        expect_at("rst_c1",    1,  1'b1, 1'b1, 4'hF, 8'hFF, 3'd0, 1'b0);
        expect_at("rst_c2",    2,  1'b1, 1'b1, 4'hF, 8'hFF, 3'd0, 1'b0);
        expect_at("rst_c3",    3,  1'b1, 1'b1, 4'hF, 8'hFF, 3'd0, 1'b0);
        expect_at("scan_d0",   4,  1'b1, 1'b1, 4'hE, 8'hC0, 3'd0, 1'b0);
        expect_at("hold_d0",   6,  1'b1, 1'b1, 4'hE, 8'hC0, 3'd0, 1'b0);
        expect_at("scan_d1",   8,  1'b1, 1'b1, 4'hD, 8'hF9, 3'd0, 1'b0);
        expect_at("scan_d2",   12, 1'b1, 1'b1, 4'hB, 8'hA4, 3'd0, 1'b0);
        expect_at("scan_d3",   16, 1'b1, 1'b1, 4'h7, 8'hB0, 3'd0, 1'b0);
        expect_at("scan_wrap", 20, 1'b1, 1'b1, 4'hE, 8'hC0, 3'd0, 1'b0);

        // Scroll-left: mode change lands on edge 22, steps then every 32 cycles from 54
        while (cyc < 21) tick();
        mode = 2'b01;
        expect_at("sl_d1",     24,  1'b1, 1'b1, 4'hD, 8'hF9, 3'd0, 1'b0);
        expect_at("sl_off1",   54,  1'b0, 1'b1, 4'h0, 8'h00, 3'd1, 1'b1);
        expect_at("sl_pulse",  55,  1'b0, 1'b1, 4'h0, 8'h00, 3'd1, 1'b0);
        expect_at("sl_off2",   86,  1'b0, 1'b1, 4'h0, 8'h00, 3'd2, 1'b1);
        expect_at("sl_off3",   118, 1'b0, 1'b1, 4'h0, 8'h00, 3'd3, 1'b1);
        expect_at("sl_off4",   150, 1'b0, 1'b1, 4'h0, 8'h00, 3'd4, 1'b1);
        expect_at("sl_off5",   182, 1'b0, 1'b1, 4'h0, 8'h00, 3'd5, 1'b1);
        expect_at("sl_o5_d2",  188, 1'b1, 1'b1, 4'hB, 8'hF9, 3'd5, 1'b0);
        expect_at("sl_o5_d0",  196, 1'b1, 1'b1, 4'hE, 8'h92, 3'd5, 1'b0);
        expect_at("sl_o5_d1",  200, 1'b1, 1'b1, 4'hD, 8'hC0, 3'd5, 1'b0);
        expect_at("sl_wrap",   214, 1'b0, 1'b1, 4'h0, 8'h00, 3'd0, 1'b1);

        // Scroll-right from reset; MODE differs from the reset mode on edge 1
        do_reset(2'b10, 24'h543210, 6'h00);
        expect_at("sr_pre",    32, 1'b0, 1'b1, 4'h0, 8'h00, 3'd0, 1'b0);
        expect_at("sr_off5",   33, 1'b0, 1'b1, 4'h0, 8'h00, 3'd5, 1'b1);
        expect_at("sr_o5_d0",  36, 1'b1, 1'b1, 4'hE, 8'h92, 3'd5, 1'b0);
        expect_at("sr_o5_d1",  40, 1'b1, 1'b1, 4'hD, 8'hC0, 3'd5, 1'b0);
        expect_at("sr_off4",   65, 1'b0, 1'b1, 4'h0, 8'h00, 3'd4, 1'b1);
        expect_at("sr_hold",   96, 1'b0, 1'b1, 4'h0, 8'h00, 3'd4, 1'b0);
        mode = 2'b00;
        expect_at("sr_chg",    97,  1'b0, 1'b0, 4'h0, 8'h00, 3'd0, 1'b0);
        expect_at("st_step",   129, 1'b0, 1'b1, 4'h0, 8'h00, 3'd0, 1'b1);

        // Walk with DP on nibble 0 (value 8)
        do_reset(2'b11, 24'h543218, 6'h01);
        expect_at("wk_d0",     4,   1'b1, 1'b1, 4'hE, 8'h00, 3'd0, 1'b0);
        expect_at("wk_s1_off", 8,   1'b1, 1'b1, 4'hF, 8'hFF, 3'd0, 1'b0);
        expect_at("wk_s2_off", 12,  1'b1, 1'b1, 4'hF, 8'hFF, 3'd0, 1'b0);
        expect_at("wk_step1",  33,  1'b0, 1'b1, 4'h0, 8'h00, 3'd0, 1'b1);
        expect_at("wk_s0_off", 36,  1'b1, 1'b1, 4'hF, 8'hFF, 3'd0, 1'b0);
        expect_at("wk_w1",     40,  1'b1, 1'b1, 4'hD, 8'hF9, 3'd0, 1'b0);
        expect_at("wk_w2",     76,  1'b1, 1'b1, 4'hB, 8'hA4, 3'd0, 1'b0);
        expect_at("wk_w3",     112, 1'b1, 1'b1, 4'h7, 8'hB0, 3'd0, 1'b0);
        expect_at("wk_w0",     132, 1'b1, 1'b1, 4'hE, 8'h00, 3'd0, 1'b0);
        expect_at("wk_s1_blk", 136, 1'b1, 1'b1, 4'hF, 8'hFF, 3'd0, 1'b0);

        // EN low freezes everything; RST mid-scroll
        do_reset(2'b01, 24'h543210, 6'h00);
        expect_at("en_off1",   33,  1'b0, 1'b1, 4'h0, 8'h00, 3'd1, 1'b1);
        expect_at("en_off2",   65,  1'b0, 1'b1, 4'h0, 8'h00, 3'd2, 1'b1);
        expect_at("en_d0",     68,  1'b1, 1'b1, 4'hE, 8'hA4, 3'd2, 1'b0);
        expect_at("en_pre",    70,  1'b1, 1'b1, 4'hE, 8'hA4, 3'd2, 1'b0);
        en = 1'b0;
        expect_at("en_blank",  71,  1'b1, 1'b1, 4'hF, 8'hFF, 3'd2, 1'b0);
        expect_at("en_frozen", 120, 1'b1, 1'b1, 4'hF, 8'hFF, 3'd2, 1'b0);
        while (cyc < 170) tick();
        en = 1'b1;
        expect_at("re_blank",  171, 1'b1, 1'b1, 4'hF, 8'hFF, 3'd2, 1'b0);
        expect_at("re_d1",     172, 1'b1, 1'b1, 4'hD, 8'hB0, 3'd2, 1'b0);
        expect_at("re_d3",     196, 1'b1, 1'b1, 4'h7, 8'h92, 3'd2, 1'b0);
        expect_at("re_off3",   197, 1'b0, 1'b1, 4'h0, 8'h00, 3'd3, 1'b1);
        expect_at("re_d0",     200, 1'b1, 1'b1, 4'hE, 8'hB0, 3'd3, 1'b0);
        rst = 1'b1;
        expect_at("rst_mid",   201, 1'b1, 1'b1, 4'hF, 8'hFF, 3'd0, 1'b0);
        rst = 1'b0;
        cyc = 0;
        expect_at("rst2_c3",   3,   1'b1, 1'b1, 4'hF, 8'hFF, 3'd0, 1'b0);
        expect_at("rst2_d0",   4,   1'b1, 1'b1, 4'hE, 8'hC0, 3'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
